grf_wb_arbiter: RTL and testbench
=================================

Name: grf_wb_arbiter

Overview:
- Shares the single write port of the general register file (a3/wd3/we) between two writeback requesters: port 0 is the main pipeline writeback, port 1 is the multi-cycle unit (MDU/load return).
- Each requester has a 2-entry queue. A round-robin arbiter drains the queues into a registered write stage that drives the register file.
- Per-address pending queries feed the hazard/stall unit, so reads of a register with a queued write can be held off.

Parameters:
DEPTH, 2, entries per requester queue (power of two, >=2)
AW, 5, register address width
DW, 32, register data width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
req0_valid  in  1  port 0 write request
req0_ready  out  1  port 0 can accept
req0_addr  in  AW  port 0 destination register
req0_data  in  DW  port 0 write data
req1_valid  in  1  port 1 write request
req1_ready  out  1  port 1 can accept
req1_addr  in  AW  port 1 destination register
req1_data  in  DW  port 1 write data
grf_a3  out  AW  register file write address
grf_wd3  out  DW  register file write data
grf_we  out  1  register file write enable
q_addr1  in  AW  pending-query address 1
q_addr2  in  AW  pending-query address 2
q_pend1  out  1  write pending to q_addr1
q_pend2  out  1  write pending to q_addr2
idle  out  1  no queued or issuing writes

Behaviour:
- Reset (reset==0, async):
  - Queues emptied.
  - grf_we=0, grf_a3=0, grf_wd3=0.
  - last_grant=1, so port 0 wins the first tie.
  - reqN_ready forced 0 while reset is low.
  - A reset mid-operation discards all queued and issuing writes. No partial write reaches the register file after reset asserts.
- Handshake:
  - reqN_ready = queue N not full. It depends on registered state only, never on valid or on the same-cycle pop.
  - A transfer occurs at a posedge with valid&ready.
  - A full queue does not accept, even if it is popped in the same cycle.
  - Port holds addr/data stable while valid&!ready.
- Zero register: a request with addr==0 is accepted (handshake completes) but not enqueued. It never produces grf_we and never sets a pend bit.
- Arbitration, evaluated every cycle on the queue heads:
  - Neither queue non-empty -> no grant.
  - Exactly one non-empty -> that queue is granted.
  - Both non-empty -> the port != last_grant is granted.
  - last_grant updates only when a grant occurs.
- Write stage (registered):
  - At each posedge: grant present -> pop head, grf_we<=1, grf_a3<=head addr, grf_wd3<=head data. Otherwise grf_we<=0; a3/wd3 hold their values.
  - Throughput: one write per cycle total.
- Latency: request accepted at edge N -> grf_we=1 during cycle N+1 (if granted at N+1) -> register file updated at edge N+2.
- Ordering:
  - FIFO order is preserved within each port.
  - Cross-port ordering to the same address follows grant order. Requesters must not issue conflicting writes to one address from both ports.
- Simultaneous push/pop on a non-full queue: both take effect, and count is unchanged.
- Pending queries (combinational):
  - q_pendK=1 iff q_addrK!=0 and q_addrK matches the addr of any valid queue entry (either port) or (grf_we && grf_a3==q_addrK).
  - Entries being pushed this cycle are not included.
- idle = both queues empty && !grf_we.
- Counters: per-queue read/write pointers wrap modulo DEPTH; an occupancy count of width clog2(DEPTH)+1 distinguishes full from empty.

Decomposition:
- Shared package holds:
  - AW/DW defaults.
  - REG_ZERO constant (5'd0).
  - Port index constants P_WB=0, P_MC=1.
- Sub-module grf_wq_fifo (DEPTH-entry addr+data queue) is instantiated twice. It exposes:
  - push/pop, full/empty, head addr/data.
  - Per-entry valid+addr vectors, used by the pend compare.
- Arbiter, write stage and pend logic live in the top module.

Test Plan:
1. Reset release, idle: assert reset=0 mid-stream with queues full -> grf_we=0, idle=1, both ready=0. On release, ready=1.
2. Single write: req0 addr=5, data=32'hDEADBEEF accepted at edge N -> grf_we=1, a3=5, wd3=DEADBEEF in cycle N+1, then grf_we=0. q_addr1=5 gives q_pend1=1 from after edge N through cycle N+1, and 0 after.
3. Contention: both ports hold valid continuously. Port 0 sends addrs 1,2,3; port 1 sends 9,10,11 -> grf_a3 sequence 1,9,2,10,3,11 with grf_we=1 every cycle.
4. Back-pressure: port 1 pushes 3 writes while port 0 saturates and arbitration favors port 0 -> req1_ready=0 once 2 entries are queued, and the 3rd is held until a pop frees space. No writes are lost or reordered.
5. Zero register: req0 addr=0, data=32'h1234 -> handshake completes, grf_we never asserts for it, q_pend with q_addr=0 stays 0, idle stays 1.
6. Push on full with same-cycle pop: queue 0 full and granted, req0_valid=1 -> req0_ready=0 that cycle and no accept. Accepted next cycle -> count returns to 2.

Source files
------------

// File: rtl/grf_wb_arbiter_pkg.sv
// Shared constants for the register-file writeback arbiter: default widths,
// the hard-wired zero register and requester port indices.
package grf_wb_arbiter_pkg;

  localparam int unsigned DEPTH_DEF = 2;
  localparam int unsigned AW_DEF    = 5;
  localparam int unsigned DW_DEF    = 32;

  localparam logic [AW_DEF-1:0] REG_ZERO = 5'd0;

  localparam logic P_WB = 1'b0;
  localparam logic P_MC = 1'b1;

endpackage

// File: rtl/grf_wq_fifo.sv
// DEPTH-entry address+data writeback queue; exposes per-entry valid/address so
// the owner can answer "is a write to register X still pending".
module grf_wq_fifo
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [AW-1:0]            push_addr,
  input  logic [DW-1:0]            push_data,
  output logic                     full_c,
  output logic                     empty_c,
  output logic [AW-1:0]            head_addr_c,
  output logic [DW-1:0]            head_data_c,
  output logic [DEPTH-1:0]         ent_valid_c,
  output logic [DEPTH-1:0][AW-1:0] ent_addr_c
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [PW-1:0]            wp;
  logic [PW-1:0]            rp;
  logic [CW-1:0]            count;
  logic [DEPTH-1:0][AW-1:0] mem_addr;
  logic [DEPTH-1:0][DW-1:0] mem_data;
  logic                     do_push;
  logic                     do_pop;
  logic [PW-1:0]            off;

  assign full_c      = (count == CW'(DEPTH));
  assign empty_c     = (count == '0);
  assign do_push     = push && !full_c;
  assign do_pop      = pop && !empty_c;
  assign head_addr_c = mem_addr[rp];
  assign head_data_c = mem_data[rp];
  assign ent_addr_c  = mem_addr;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + PW'(1);
      if (do_pop)  rp <= rp + PW'(1);
      if (do_push && !do_pop)      count <= count + CW'(1);
      else if (do_pop && !do_push) count <= count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_addr[wp] <= push_addr;
      mem_data[wp] <= push_data;
    end
  end

  // Slot i is live when its distance from the read pointer is below the count.
  always_comb begin
    ent_valid_c = '0;
    off         = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      off            = PW'(i) - rp;
      ent_valid_c[i] = ({1'b0, off} < count);
    end
  end

endmodule

// File: rtl/grf_wb_arbiter.sv
// Round-robin sharing of the register-file write port between the pipeline
// writeback (port 0) and the multi-cycle unit (port 1), with pending queries.
module grf_wb_arbiter
  import grf_wb_arbiter_pkg::*;
#(
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned AW    = AW_DEF,
  parameter int unsigned DW    = DW_DEF
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          req0_valid,
  output logic          req0_ready,
  input  logic [AW-1:0] req0_addr,
  input  logic [DW-1:0] req0_data,
  input  logic          req1_valid,
  output logic          req1_ready,
  input  logic [AW-1:0] req1_addr,
  input  logic [DW-1:0] req1_data,
  output logic [AW-1:0] grf_a3,
  output logic [DW-1:0] grf_wd3,
  output logic          grf_we,
  input  logic [AW-1:0] q_addr1,
  input  logic [AW-1:0] q_addr2,
  output logic          q_pend1,
  output logic          q_pend2,
  output logic          idle
);

  logic                     push0, push1;
  logic                     full0, full1;
  logic                     empty0, empty1;
  logic                     gnt0, gnt1;
  logic                     last_grant;
  logic [AW-1:0]            head_addr0, head_addr1;
  logic [DW-1:0]            head_data0, head_data1;
  logic [DEPTH-1:0]         ev0, ev1;
  logic [DEPTH-1:0][AW-1:0] ea0, ea1;

  // Ready comes from registered occupancy only; zero-register writes are swallowed.
  assign req0_ready = reset && !full0;
  assign req1_ready = reset && !full1;
  assign push0      = req0_valid && req0_ready && (req0_addr != AW'(REG_ZERO));
  assign push1      = req1_valid && req1_ready && (req1_addr != AW'(REG_ZERO));
  assign idle       = empty0 && empty1 && !grf_we;

  grf_wq_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_q0 (
    .clk         (clk),
    .reset       (reset),
    .push        (push0),
    .pop         (gnt0),
    .push_addr   (req0_addr),
    .push_data   (req0_data),
    .full_c      (full0),
    .empty_c     (empty0),
    .head_addr_c (head_addr0),
    .head_data_c (head_data0),
    .ent_valid_c (ev0),
    .ent_addr_c  (ea0)
  );

  grf_wq_fifo #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) u_q1 (
    .clk         (clk),
    .reset       (reset),
    .push        (push1),
    .pop         (gnt1),
    .push_addr   (req1_addr),
    .push_data   (req1_data),
    .full_c      (full1),
    .empty_c     (empty1),
    .head_addr_c (head_addr1),
    .head_data_c (head_data1),
    .ent_valid_c (ev1),
    .ent_addr_c  (ea1)
  );

  // On a tie the port that did not win last time is served.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (!empty0 && !empty1) begin
      gnt0 = (last_grant != P_WB);
      gnt1 = (last_grant == P_WB);
    end else begin
      gnt0 = !empty0;
      gnt1 = !empty1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      grf_we     <= 1'b0;
      grf_a3     <= '0;
      grf_wd3    <= '0;
      last_grant <= P_MC;
    end else begin
      grf_we <= gnt0 || gnt1;
      if (gnt0) begin
        grf_a3     <= head_addr0;
        grf_wd3    <= head_data0;
        last_grant <= P_WB;
      end else if (gnt1) begin
        grf_a3     <= head_addr1;
        grf_wd3    <= head_data1;
        last_grant <= P_MC;
      end
    end
  end

  // A register is pending while any queue slot or the issuing write targets it.
  always_comb begin
    q_pend1 = grf_we && (grf_a3 == q_addr1);
    q_pend2 = grf_we && (grf_a3 == q_addr2);
    for (int unsigned i = 0; i < DEPTH; i++) begin
      q_pend1 = q_pend1 || (ev0[i] && (ea0[i] == q_addr1)) || (ev1[i] && (ea1[i] == q_addr1));
      q_pend2 = q_pend2 || (ev0[i] && (ea0[i] == q_addr2)) || (ev1[i] && (ea1[i] == q_addr2));
    end
    if (q_addr1 == AW'(REG_ZERO)) q_pend1 = 1'b0;
    if (q_addr2 == AW'(REG_ZERO)) q_pend2 = 1'b0;
  end

endmodule

// File: tb/tb_grf_wb_arbiter.sv
// Self-checking bench for grf_wb_arbiter: scoreboard of accepted writes,
// single-write vector table and directed contention/back-pressure/reset runs.
module tb_grf_wb_arbiter;

  localparam int unsigned DEPTH = 2;
  localparam int unsigned AW    = 5;
  localparam int unsigned DW    = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          req0_valid = 1'b0;
  logic          req0_ready;
  logic [AW-1:0] req0_addr = '0;
  logic [DW-1:0] req0_data = '0;
  logic          req1_valid = 1'b0;
  logic          req1_ready;
  logic [AW-1:0] req1_addr = '0;
  logic [DW-1:0] req1_data = '0;
  logic [AW-1:0] grf_a3;
  logic [DW-1:0] grf_wd3;
  logic          grf_we;
  logic [AW-1:0] q_addr1 = '0;
  logic [AW-1:0] q_addr2 = '0;
  logic          q_pend1;
  logic          q_pend2;
  logic          idle;

  grf_wb_arbiter #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk        (clk),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .grf_a3     (grf_a3),
    .grf_wd3    (grf_wd3),
    .grf_we     (grf_we),
    .q_addr1    (q_addr1),
    .q_addr2    (q_addr2),
    .q_pend1    (q_pend1),
    .q_pend2    (q_pend2),
    .idle       (idle)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } wr_t;

  typedef struct packed {
    logic        port;
    logic [4:0]  a;
    logic [31:0] d;
  } vec_t;

  wr_t        sb0[$];
  wr_t        sb1[$];
  wr_t        st0[$];
  wr_t        st1[$];
  logic [4:0] wlog[$];
  int         wcyc[$];
  logic [4:0] exp_q[$];
  logic       rl0[$];
  logic       rl1[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  int         cyc = 0;
  logic       saw_r1_low = 1'b0;
  logic       wrote;
  logic [4:0] cur;
  logic       ep1, ep2;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic logic exp_pend(input logic [4:0] q, input logic wr, input logic [4:0] c);
    logic h;
    if (q == 5'd0) return 1'b0;
    h = wr && (c == q);
    foreach (sb0[i]) if (sb0[i].a == q) h = 1'b1;
    foreach (sb1[i]) if (sb1[i].a == q) h = 1'b1;
    return h;
  endfunction

  // Scoreboard: retire each register-file write against the oldest accepted
  // entry of either port, then check ready/pending/idle against what is queued.
  always @(negedge clk) begin
    cyc++;
    wrote = 1'b0;
    cur   = 5'd0;
    if (!reset) begin
      sb0.delete();
      sb1.delete();
      chk("rst_we", 32'(grf_we), 32'd0);
      chk("rst_a3", 32'(grf_a3), 32'd0);
      chk("rst_wd3", grf_wd3, 32'd0);
      chk("rst_idle", 32'(idle), 32'd1);
      chk("rst_rdy0", 32'(req0_ready), 32'd0);
      chk("rst_rdy1", 32'(req1_ready), 32'd0);
    end else begin
      if (grf_we !== 1'b0) begin
        wrote = 1'b1;
        n_cmp++;
        if (sb0.size() > 0 && sb0[0].a == grf_a3 && sb0[0].d == grf_wd3) begin
          cur = sb0[0].a;
          void'(sb0.pop_front());
        end else if (sb1.size() > 0 && sb1[0].a == grf_a3 && sb1[0].d == grf_wd3) begin
          cur = sb1[0].a;
          void'(sb1.pop_front());
        end else begin
          n_bad++;
          $display("FAIL sb_write: got a3=%0d wd3=%0h we=%b, required a queued head (cycle %0d)",
                   grf_a3, grf_wd3, grf_we, cyc);
        end
        wlog.push_back(grf_a3);
        wcyc.push_back(cyc);
      end
      chk("rdy0", 32'(req0_ready), 32'(sb0.size() < 2));
      chk("rdy1", 32'(req1_ready), 32'(sb1.size() < 2));
      ep1 = exp_pend(q_addr1, wrote, cur);
      ep2 = exp_pend(q_addr2, wrote, cur);
      chk("pend1", 32'(q_pend1), 32'(ep1));
      chk("pend2", 32'(q_pend2), 32'(ep2));
      chk("idle", 32'(idle), 32'(sb0.size() == 0 && sb1.size() == 0 && !wrote));
      if (!req1_ready) saw_r1_low = 1'b1;
      if (req0_valid && req0_ready && req0_addr != 5'd0) sb0.push_back({req0_addr, req0_data});
      if (req1_valid && req1_ready && req1_addr != 5'd0) sb1.push_back({req1_addr, req1_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input int port, input logic [4:0] a);
    if (port == 0) st0.push_back({a, 32'hA000_0000 | 32'(a)});
    else           st1.push_back({a, 32'hB000_0000 | 32'(a)});
  endtask

  // Present both streams, each port advancing only when its handshake completes.
  task automatic run_streams(input int budget);
    int   i0, i1, n;
    logic a0, a1;
    i0 = 0; i1 = 0; n = 0;
    rl0.delete();
    rl1.delete();
    while ((i0 < st0.size() || i1 < st1.size()) && n < budget) begin
      req0_valid = (i0 < st0.size());
      if (req0_valid) begin req0_addr = st0[i0].a; req0_data = st0[i0].d; end
      req1_valid = (i1 < st1.size());
      if (req1_valid) begin req1_addr = st1[i1].a; req1_data = st1[i1].d; end
      q_addr1 = req0_addr;
      q_addr2 = 5'($urandom_range(0, 31));
      @(negedge clk);
      a0 = req0_valid && req0_ready;
      a1 = req1_valid && req1_ready;
      rl0.push_back(req0_ready);
      rl1.push_back(req1_ready);
      tick();
      if (a0) i0++;
      if (a1) i1++;
      n++;
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    chk("stream_done", 32'(i0 + i1), 32'(st0.size() + st1.size()));
    st0.delete();
    st1.delete();
  endtask

  function automatic logic [31:0] pack_rl(input logic q[$]);
    logic [31:0] v;
    v = '0;
    foreach (q[i]) v = {v[30:0], q[i]};
    return v;
  endfunction

  task automatic chk_wlog(input string nm, input logic contig);
    chk({nm, "_len"}, 32'(wlog.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < wlog.size(); i++) begin
      chk(nm, 32'(wlog[i]), 32'(exp_q[i]));
      if (contig) chk({nm, "_cyc"}, 32'(wcyc[i]), 32'(wcyc[0] + i));
    end
    exp_q.delete();
    wlog.delete();
    wcyc.delete();
  endtask

  vec_t vt[6];

  initial begin
    vt[0] = '{port: 1'b0, a: 5'd5,  d: 32'hDEAD_BEEF};
    vt[1] = '{port: 1'b0, a: 5'd0,  d: 32'h0000_1234};
    vt[2] = '{port: 1'b1, a: 5'd31, d: 32'hCAFE_F00D};
    vt[3] = '{port: 1'b1, a: 5'd0,  d: 32'h0000_5555};
    vt[4] = '{port: 1'b0, a: 5'd17, d: 32'h0000_0000};
    vt[5] = '{port: 1'b1, a: 5'd1,  d: 32'hFFFF_FFFF};

    #1 reset = 1'b0;
    repeat (2) tick();
    reset = 1'b1;
    @(negedge clk);
    chk("rel_rdy0", 32'(req0_ready), 32'd1);
    chk("rel_rdy1", 32'(req1_ready), 32'd1);
    tick();

    // Contention straight out of reset: port 0 wins the first tie.
    wlog.delete(); wcyc.delete();
    add(0, 5'd1); add(0, 5'd2); add(0, 5'd3);
    add(1, 5'd9); add(1, 5'd10); add(1, 5'd11);
    run_streams(20);
    chk("t3_rdy0", pack_rl(rl0), 32'b1110);
    chk("t3_rdy1", pack_rl(rl1), 32'b1101);
    repeat (6) tick();
    exp_q = '{5'd1, 5'd9, 5'd2, 5'd10, 5'd3, 5'd11};
    chk_wlog("t3_seq", 1'b1);

    // Single writes: acceptance, one-cycle queue residency, write, then idle.
    foreach (vt[k]) begin
      if (vt[k].port) begin req1_valid = 1'b1; req1_addr = vt[k].a; req1_data = vt[k].d; end
      else            begin req0_valid = 1'b1; req0_addr = vt[k].a; req0_data = vt[k].d; end
      q_addr1 = vt[k].a;
      q_addr2 = 5'd0;
      @(negedge clk);
      chk("v_ready", 32'(vt[k].port ? req1_ready : req0_ready), 32'd1);
      chk("v_pend_pre", 32'(q_pend1), 32'd0);
      tick();
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      chk("v_pend_q", 32'(q_pend1), 32'(vt[k].a != 5'd0));
      chk("v_we_q", 32'(grf_we), 32'd0);
      chk("v_idle_q", 32'(idle), 32'(vt[k].a == 5'd0));
      tick();
      @(negedge clk);
      chk("v_we", 32'(grf_we), 32'(vt[k].a != 5'd0));
      chk("v_pend_w", 32'(q_pend1), 32'(vt[k].a != 5'd0));
      chk("v_pend2", 32'(q_pend2), 32'd0);
      if (vt[k].a != 5'd0) begin
        chk("v_a3", 32'(grf_a3), 32'(vt[k].a));
        chk("v_wd3", grf_wd3, vt[k].d);
      end
      tick();
      @(negedge clk);
      chk("v_we_off", 32'(grf_we), 32'd0);
      chk("v_pend_off", 32'(q_pend1), 32'd0);
      chk("v_idle_end", 32'(idle), 32'd1);
      tick();
    end
    wlog.delete(); wcyc.delete();

    // Port 0 served last, so port 1 wins the tie and queue 0 fills while granted.
    add(0, 5'd12);
    run_streams(10);
    repeat (4) tick();
    wlog.delete(); wcyc.delete();
    add(0, 5'd13); add(0, 5'd14); add(0, 5'd15);
    add(1, 5'd21); add(1, 5'd22); add(1, 5'd23);
    run_streams(20);
    chk("t6_rdy0", pack_rl(rl0), 32'b1101);
    chk("t6_rdy1", pack_rl(rl1), 32'b1110);
    @(negedge clk);
    chk("t6_refull", 32'(req0_ready), 32'd0);
    tick();
    repeat (6) tick();
    exp_q = '{5'd21, 5'd13, 5'd22, 5'd14, 5'd23, 5'd15};
    chk_wlog("t6_seq", 1'b1);

    // Back-pressure on port 1 while port 0 streams continuously.
    saw_r1_low = 1'b0;
    for (int i = 2; i < 8; i++) add(0, 5'(i));
    add(1, 5'd24); add(1, 5'd25); add(1, 5'd26);
    run_streams(40);
    repeat (8) tick();
    chk("t4_r1_low", 32'(saw_r1_low), 32'd1);
    chk("t4_nwr", 32'(wlog.size()), 32'd9);
    wlog.delete(); wcyc.delete();

    // Reset mid-stream discards everything; nothing stale is written afterwards.
    req0_valid = 1'b1; req0_addr = 5'd8;  req0_data = 32'hA000_0008;
    req1_valid = 1'b1; req1_addr = 5'd18; req1_data = 32'hB000_0012;
    repeat (4) tick();
    @(negedge clk);
    chk("mid_busy", 32'(idle), 32'd0);
    tick();
    reset = 1'b0;
    #1;
    chk("ar_we", 32'(grf_we), 32'd0);
    chk("ar_idle", 32'(idle), 32'd1);
    chk("ar_rdy0", 32'(req0_ready), 32'd0);
    chk("ar_rdy1", 32'(req1_ready), 32'd0);
    repeat (2) tick();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    chk("rr_rdy0", 32'(req0_ready), 32'd1);
    chk("rr_rdy1", 32'(req1_ready), 32'd1);
    chk("rr_idle", 32'(idle), 32'd1);
    tick();
    repeat (4) tick();
    wlog.delete(); wcyc.delete();

    // Tie priority is restored by reset.
    add(0, 5'd4); add(1, 5'd14);
    run_streams(10);
    repeat (4) tick();
    exp_q = '{5'd4, 5'd14};
    chk_wlog("post_rst_seq", 1'b1);

    chk("lost0", 32'(sb0.size()), 32'd0);
    chk("lost1", 32'(sb1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog");
  end

endmodule
